// File: rtl/cd_csr_arb_pkg.sv
// Shared types and constants for the two-requester CSR arbiter.
// Tie policy is chosen by CD_CSR_ARB_FIXED_PRIO_EN in cd_csr_arb.
package cd_csr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] REG_INT_FLAG = 4'h9;

endpackage

// File: rtl/cd_rr_pick.sv
// Grant selection for two requesters: on a tie the requester not granted last wins.
module cd_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_grant
);

  always_comb begin
    o_grant = 1'b0;
    if (i_req == 2'b11) begin
      o_grant = ~i_last;
    end else if (i_req[1]) begin
      o_grant = 1'b1;
    end
  end

endmodule

// File: rtl/cd_csr_arb.sv
// Arbitrates two requesters onto one CSR port: IDLE -> ISSUE -> RESP, one access at a time.
// Define CD_CSR_ARB_FIXED_PRIO_EN for fixed m0-wins ties instead of round-robin.
module cd_csr_arb
  import cd_csr_arb_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic [31:0]       m0_readdata,
  output logic              m0_ack,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic [31:0]       m1_readdata,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] csr_address,
  output logic [3:0]        csr_byteenable,
  output logic              csr_read,
  output logic              csr_write,
  output logic [31:0]       csr_writedata,
  input  logic [31:0]       csr_readdata,
  output logic              busy
);

  state_t r_state;
  state_t w_next;

  logic [1:0]        w_req;
  logic              w_grant;
  logic              w_last;
  logic              w_selWrite;
  logic              w_selRead;
  logic              w_take;

  logic              r_grant;
  logic              r_isRead;
  logic              r_isWrite;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;

  assign w_req  = {m1_read | m1_write, m0_read | m0_write};
  assign w_take = (r_state == IDLE) && (|w_req);

`ifdef CD_CSR_ARB_FIXED_PRIO_EN
  assign w_last = 1'b1;
`else
  logic r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (w_take) begin
      r_last <= w_grant;
    end
  end

  assign w_last = r_last;
`endif

  cd_rr_pick u_pick (
    .i_req   (w_req),
    .i_last  (w_last),
    .o_grant (w_grant)
  );

  // A simultaneous read+write is demoted to a write only.
  assign w_selWrite = w_grant ? m1_write : m0_write;
  assign w_selRead  = (w_grant ? m1_read : m0_read) & ~w_selWrite;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|w_req) w_next = ISSUE;
      ISSUE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant   <= 1'b0;
      r_isRead  <= 1'b0;
      r_isWrite <= 1'b0;
      r_addr    <= '0;
      r_be      <= 4'h0;
      r_wdata   <= 32'h0;
    end else if (w_take) begin
      r_grant   <= w_grant;
      r_isRead  <= w_selRead;
      r_isWrite <= w_selWrite;
      r_addr    <= w_grant ? m1_address    : m0_address;
      r_be      <= w_grant ? m1_byteenable : m0_byteenable;
      r_wdata   <= w_grant ? m1_writedata  : m0_writedata;
    end
  end

  // Read data is captured at the end of ISSUE so it is valid alongside the ack in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_readdata <= 32'h0;
      m1_readdata <= 32'h0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      if (r_state == ISSUE) begin
        if (r_grant) begin
          m1_ack <= 1'b1;
          if (r_isRead) m1_readdata <= csr_readdata;
        end else begin
          m0_ack <= 1'b1;
          if (r_isRead) m0_readdata <= csr_readdata;
        end
      end
    end
  end

  assign csr_read       = (r_state == ISSUE) && r_isRead;
  assign csr_write      = (r_state == ISSUE) && r_isWrite;
  assign csr_address    = r_addr;
  assign csr_byteenable = r_be;
  assign csr_writedata  = r_wdata;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_cd_csr_arb.sv
// Directed bench for cd_csr_arb; honours CD_CSR_ARB_FIXED_PRIO_EN for the tie-order expectations.
module tb_cd_csr_arb;
  import cd_csr_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  m0_address = 4'h0, m1_address = 4'h0;
  logic [3:0]  m0_byteenable = 4'h0, m1_byteenable = 4'h0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = 32'h0, m1_writedata = 32'h0;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_ack, m1_ack;
  logic [3:0]  csr_address;
  logic [3:0]  csr_byteenable;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;
  logic        busy;

  logic [31:0] slaveData = 32'h0;
  logic [31:0] intFlag = 32'h0;
  logic        loadFlag = 1'b0;
  int          readPulses = 0;
  int          writePulses = 0;
  int          flagReads = 0;
  int          checks = 0;
  int          errors = 0;

  cd_csr_arb #(.ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_ack(m0_ack),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_ack(m1_ack),
    .csr_address(csr_address), .csr_byteenable(csr_byteenable), .csr_read(csr_read),
    .csr_write(csr_write), .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // Slave model: INT_FLAG clears on read, every other address returns slaveData.
  assign csr_readdata = (csr_address == REG_INT_FLAG) ? intFlag : slaveData;

  always @(posedge clk) begin
    if (loadFlag) intFlag <= 32'h0000_00a5;
    else if (csr_read && csr_address == REG_INT_FLAG) intFlag <= 32'h0;
  end

  always @(posedge clk) begin
    if (csr_read) readPulses++;
    if (csr_write) writePulses++;
    if (csr_read && csr_address == REG_INT_FLAG) flagReads++;
  end

  task automatic doReset();
    reset = 1'b1;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    checks++; if (csr_read !== 1'b0 || csr_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes got %b%b exp 00", csr_read, csr_write); end
    checks++; if (csr_address !== 4'h0 || csr_byteenable !== 4'h0 || csr_writedata !== 32'h0) begin errors++; $display("[TB] FAIL reset_cmd got %h %h %h exp 0 0 0", csr_address, csr_byteenable, csr_writedata); end
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %b%b exp 00", m0_ack, m1_ack); end
    checks++; if (m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h %h exp 0 0", m0_readdata, m1_readdata); end
  endtask

  task automatic test_write();
    int w0;
    w0 = writePulses;
    m0_address = 4'h2; m0_writedata = 32'h0000_0014; m0_byteenable = 4'h1; m0_write = 1'b1;
    @(negedge clk);
    checks++; if (csr_write !== 1'b1 || csr_read !== 1'b0) begin errors++; $display("[TB] FAIL wr_strobe got w%b r%b exp w1 r0", csr_write, csr_read); end
    checks++; if (csr_address !== 4'h2 || csr_writedata !== 32'h0000_0014 || csr_byteenable !== 4'h1) begin errors++; $display("[TB] FAIL wr_cmd got %h %h %h exp 2 00000014 1", csr_address, csr_writedata, csr_byteenable); end
    checks++; if (busy !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("[TB] FAIL wr_issue got busy %b ack %b exp 1 0", busy, m0_ack); end
    @(negedge clk);
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("[TB] FAIL wr_ack got %b%b exp 10", m0_ack, m1_ack); end
    checks++; if (csr_write !== 1'b0) begin errors++; $display("[TB] FAIL wr_resp_strobe got %b exp 0", csr_write); end
    m0_write = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || m0_ack !== 1'b0) begin errors++; $display("[TB] FAIL wr_done got busy %b ack %b exp 0 0", busy, m0_ack); end
    checks++; if (m0_readdata !== 32'h0 || writePulses - w0 !== 1) begin errors++; $display("[TB] FAIL wr_side got rdata %h pulses %0d exp 0 1", m0_readdata, writePulses - w0); end
  endtask

  task automatic test_read();
    int r0;
    r0 = readPulses;
    slaveData = 32'h0000_000e;
    m1_address = 4'h0; m1_byteenable = 4'hf; m1_read = 1'b1;
    @(negedge clk);
    checks++; if (csr_read !== 1'b1 || csr_address !== 4'h0) begin errors++; $display("[TB] FAIL rd_strobe got r%b a%h exp r1 a0", csr_read, csr_address); end
    @(negedge clk);
    checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("[TB] FAIL rd_ack got %b%b exp 01", m1_ack, m0_ack); end
    checks++; if (m1_readdata !== 32'h0000_000e) begin errors++; $display("[TB] FAIL rd_data got %h exp 0000000e", m1_readdata); end
    m1_read = 1'b0;
    @(negedge clk);
    checks++; if (readPulses - r0 !== 1) begin errors++; $display("[TB] FAIL rd_pulses got %0d exp 1", readPulses - r0); end
    checks++; if (m0_readdata !== 32'h0) begin errors++; $display("[TB] FAIL rd_other got %h exp 0", m0_readdata); end
  endtask

  task automatic test_zero_be();
    m1_address = 4'h3; m1_byteenable = 4'h0; m1_writedata = 32'h1111_2222; m1_write = 1'b1;
    @(negedge clk);
    checks++; if (csr_write !== 1'b1 || csr_byteenable !== 4'h0 || csr_address !== 4'h3) begin errors++; $display("[TB] FAIL be0_cmd got w%b be%h a%h exp w1 be0 a3", csr_write, csr_byteenable, csr_address); end
    @(negedge clk);
    checks++; if (m1_ack !== 1'b1) begin errors++; $display("[TB] FAIL be0_ack got %b exp 1", m1_ack); end
    checks++; if (m1_readdata !== 32'h0000_000e) begin errors++; $display("[TB] FAIL be0_rdata_kept got %h exp 0000000e", m1_readdata); end
    m1_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [2:0] expWin;
    logic       win, expA0, expA1;
    int         idx, phase;
`ifdef CD_CSR_ARB_FIXED_PRIO_EN
    expWin = 3'b000;
`else
    expWin = 3'b010;
`endif
    reset = 1'b1;
    m0_address = 4'h3; m1_address = 4'h5; m0_read = 1'b1; m1_read = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      idx   = (k - 1) / 3;
      phase = (k - 1) % 3;
      win   = expWin[idx];
      expA0 = (phase == 1) && !win;
      expA1 = (phase == 1) && win;
      checks++; if (m0_ack !== expA0 || m1_ack !== expA1) begin errors++; $display("[TB] FAIL rr_ack_c%0d got %b%b exp %b%b", k, m0_ack, m1_ack, expA0, expA1); end
      if (phase == 0) begin
        checks++; if (csr_read !== 1'b1 || csr_address !== (win ? 4'h5 : 4'h3)) begin errors++; $display("[TB] FAIL rr_issue_c%0d got r%b a%h exp r1 a%h", k, csr_read, csr_address, win ? 4'h5 : 4'h3); end
      end
    end
    m0_read = 1'b0; m1_read = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int  f0, a0, a1;
    bit  merged;
    logic prevRead;
    doReset();
    loadFlag = 1'b1;
    @(negedge clk);
    loadFlag = 1'b0;
    f0 = flagReads; a0 = 0; a1 = 0; merged = 0; prevRead = 1'b0;
    m0_address = REG_INT_FLAG; m1_address = REG_INT_FLAG;
    m0_read = 1'b1; m1_read = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (csr_read && prevRead) merged = 1;
      prevRead = csr_read;
      if (m0_ack) begin a0++; m0_read = 1'b0; end
      if (m1_ack) begin a1++; m1_read = 1'b0; end
    end
    checks++; if (flagReads - f0 !== 2) begin errors++; $display("[TB] FAIL b2b_pulses got %0d exp 2", flagReads - f0); end
    checks++; if (merged !== 1'b0) begin errors++; $display("[TB] FAIL b2b_merged got %b exp 0", merged); end
    checks++; if (a0 !== 1 || a1 !== 1) begin errors++; $display("[TB] FAIL b2b_acks got %0d %0d exp 1 1", a0, a1); end
    checks++; if (m0_readdata !== 32'h0000_00a5 || m1_readdata !== 32'h0) begin errors++; $display("[TB] FAIL b2b_rdata got %h %h exp 000000a5 0", m0_readdata, m1_readdata); end
  endtask

  task automatic test_reset_abort();
    int w0;
    w0 = writePulses;
    m1_address = 4'h7; m1_writedata = 32'h0000_0055; m1_byteenable = 4'hf; m1_write = 1'b1;
    @(negedge clk);
    checks++; if (csr_write !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre got %b exp 1", csr_write); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (csr_write !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("[TB] FAIL abort_out got w%b ack%b exp 0 0", csr_write, m1_ack); end
    checks++; if (busy !== 1'b0 || dut.r_state !== IDLE) begin errors++; $display("[TB] FAIL abort_state got busy %b st %0d exp 0 0", busy, dut.r_state); end
    @(negedge clk);
    reset = 1'b0; m1_write = 1'b0;
    @(negedge clk);
    checks++; if (m1_ack !== 1'b0 || writePulses - w0 !== 1) begin errors++; $display("[TB] FAIL abort_after got ack %b pulses %0d exp 0 1", m1_ack, writePulses - w0); end
  endtask

  task automatic test_rw_both();
    int r0;
    slaveData = 32'h0000_1234;
    m0_address = 4'h1; m0_read = 1'b1;
    repeat (2) @(negedge clk);
    m0_read = 1'b0;
    @(negedge clk);
    checks++; if (m0_readdata !== 32'h0000_1234) begin errors++; $display("[TB] FAIL rw_setup got %h exp 00001234", m0_readdata); end
    slaveData = 32'hdead_beef;
    r0 = readPulses;
    m0_address = 4'h6; m0_writedata = 32'h0000_cafe; m0_byteenable = 4'h3;
    m0_read = 1'b1; m0_write = 1'b1;
    @(negedge clk);
    checks++; if (csr_write !== 1'b1 || csr_read !== 1'b0) begin errors++; $display("[TB] FAIL rw_strobe got w%b r%b exp w1 r0", csr_write, csr_read); end
    checks++; if (csr_address !== 4'h6 || csr_writedata !== 32'h0000_cafe) begin errors++; $display("[TB] FAIL rw_cmd got %h %h exp 6 0000cafe", csr_address, csr_writedata); end
    @(negedge clk);
    checks++; if (m0_ack !== 1'b1 || m0_readdata !== 32'h0000_1234) begin errors++; $display("[TB] FAIL rw_ack got ack %b rdata %h exp 1 00001234", m0_ack, m0_readdata); end
    m0_read = 1'b0; m0_write = 1'b0;
    @(negedge clk);
    checks++; if (readPulses - r0 !== 0) begin errors++; $display("[TB] FAIL rw_nread got %0d exp 0", readPulses - r0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_zero_be();
    test_round_robin();
    test_back_to_back();
    test_reset_abort();
    test_rw_both();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cd_csr_arb.md
CD_CSR_ARB -- requirements
Module: cd_csr_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, giving the CSR word-address width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports mN_address (input, ADDR_W) and mN_byteenable (input, 4) for each requester N=0,1: requested word address and byte lanes.
REQ-005 The block SHALL have ports mN_read and mN_write for each requester N=0,1: input, 1 bit each, the request strobes, held by the requester until mN_ack.
REQ-006 The block SHALL have port mN_writedata for each requester N=0,1: input, 32 bits, write data.
REQ-007 The block SHALL have port mN_readdata for each requester N=0,1: output reg, 32 bits, registered read result.
REQ-008 The block SHALL have port mN_ack for each requester N=0,1: output reg, 1 bit, a one-cycle completion pulse.
REQ-009 The block SHALL have ports csr_address (output, ADDR_W), csr_byteenable (output, 4), csr_read (output, 1), csr_write (output, 1) and csr_writedata (output, 32): the shared downstream CSR port.
REQ-010 The block SHALL have port csr_readdata, input, 32 bits: combinational read data from the CSR slave.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE and RESP, one cycle each except IDLE.
REQ-013 IDLE: on any pending request, the block SHALL latch the winner's address, byteenable, writedata and op into command registers and go to ISSUE; with no request it SHALL stay in IDLE.
REQ-014 ISSUE: the block SHALL drive the latched command on csr_* for exactly one cycle, capture csr_readdata into the winner's mN_readdata on a read, and go to RESP.
REQ-015 RESP: the block SHALL pulse the winner's mN_ack for one cycle and return to IDLE; requests SHALL NOT be sampled in RESP.
REQ-016 Latency from a request sampled in IDLE at cycle N SHALL be: csr strobe at N+1, ack at N+2, next grant no earlier than N+3.
REQ-017 Exactly one csr_read or csr_write pulse SHALL be issued per granted access, so that read-to-clear registers (INT_FLAG, address 4'h9) are cleared exactly once.
REQ-018 If read and write are both asserted by one requester, the block SHALL treat the access as a write only.
REQ-019 Byteenable 4'h0 SHALL be forwarded unchanged, with the access still acknowledged.
REQ-020 Round-robin: if both requesters request in IDLE, the block SHALL grant the one not granted last; a single requester SHALL always be granted.
REQ-021 The last-grant register SHALL reset to 1, so that m0 wins the first tie.
REQ-022 csr_read and csr_write SHALL be 0 outside ISSUE; csr_address, csr_byteenable and csr_writedata SHALL hold the command registers.
REQ-023 mN_readdata SHALL hold its value until the next read granted to that requester; a write SHALL NOT alter it.

Reset
REQ-024 On reset the block SHALL set the state to IDLE; all csr_* outputs, mN_ack, mN_readdata, busy and the command registers to 0; and last-grant to 1.
REQ-025 Reset asserted in ISSUE or RESP SHALL abort the access with no further csr strobe and no ack; the requester re-requests after reset.

Configuration
REQ-026 Macro CD_CSR_ARB_FIXED_PRIO_EN SHALL select the tie policy.
REQ-027 With CD_CSR_ARB_FIXED_PRIO_EN defined, m0 SHALL always win ties and the last-grant register SHALL be omitted.
REQ-028 Without CD_CSR_ARB_FIXED_PRIO_EN, round-robin per REQ-020 SHALL apply.

Structure
REQ-029 Package cd_csr_arb_pkg SHALL hold the state enum (IDLE, ISSUE, RESP) and the constant REG_INT_FLAG = 4'h9 used by benches.
REQ-030 Sub-module cd_rr_pick SHALL compute the grant from req[1:0] and last-grant; the FSM and datapath SHALL remain in cd_csr_arb.

Verification
REQ-031 The bench SHALL cover: m0 write addr 4'h2 data 32'h0000_0014 be 4'h1 -> csr_write high one cycle at N+1 with those values; m0_ack at N+2.
REQ-032 The bench SHALL cover: m1 read addr 4'h0, slave returns 32'h0000_000e -> m1_readdata = 32'h0000_000e at the m1_ack cycle; exactly one csr_read pulse.
REQ-033 The bench SHALL cover: m0 and m1 both requesting continuously from reset -> grants alternate m0, m1, m0, with 3-cycle spacing (fixed-prio build: m0 every grant).
REQ-034 The bench SHALL cover: both requesters reading 4'h9 back-to-back -> two separate csr_read pulses, never merged or duplicated.
REQ-035 The bench SHALL cover: reset asserted during ISSUE of an m1 write -> csr_write low the next cycle, no m1_ack, state IDLE, busy 0.
REQ-036 The bench SHALL cover: m0 asserts read and write together on addr 4'h6 -> only csr_write pulses; m0_readdata unchanged.
